// File: rtl/exec_unit_xcache_pkg.sv
// Shared types and sizing for the per-execution-unit operand cache (xcache).
// Entries are write-once/read-once slots keyed by local register index.
package exec_unit_xcache_pkg;

    localparam int NUM_EU           = 4;
    localparam int LOG2_NUM_EU      = 2;
    localparam int NUM_REG          = 8;
    localparam int LOG2_NUM_REG     = 3;
    localparam int NUM_ENTRIES      = NUM_REG;
    localparam int DATA_WIDTH       = 32;
    localparam int XCACHE_OCC_WIDTH = LOG2_NUM_REG + 1;

    typedef logic [LOG2_NUM_REG-1:0] type_alpu_local_addr;
    typedef logic [DATA_WIDTH-1:0]   type_data;

    typedef struct packed {
        logic                   is_output;
        logic [LOG2_NUM_EU-1:0] eu_idx;
        type_alpu_local_addr    reg_idx;
    } type_icon_addr;

    typedef struct packed {
        type_icon_addr addr;
        type_data      data;
        logic          valid;
    } type_icon_channel;

    typedef struct packed {
        logic ready;
    } type_icon_rx_channel;

    typedef struct packed {
        type_data op0_data;
        logic     op0_valid;
        type_data op1_data;
        logic     op1_valid;
        logic     opd_ready;
    } type_alpu_channel_rx;

    // has_been_read = 1 marks the slot free; 0 marks it holding unread data.
    typedef struct packed {
        type_data data;
        logic     has_been_read;
    } type_xcache_data;

    typedef struct packed {
        logic                rd_req_valid;
        type_alpu_local_addr rd_req_idx;
    } type_xcache_rd_req;

    // Two ports reading the same slot in one cycle free it only once.
    function automatic logic [XCACHE_OCC_WIDTH-1:0] distinct_frees(
        input logic acc0,
        input logic acc1,
        input logic same_idx
    );
        logic [XCACHE_OCC_WIDTH-1:0] n;
        case ({acc0, acc1})
            2'b11:   n = same_idx ? XCACHE_OCC_WIDTH'(32'd1) : XCACHE_OCC_WIDTH'(32'd2);
            2'b10:   n = XCACHE_OCC_WIDTH'(32'd1);
            2'b01:   n = XCACHE_OCC_WIDTH'(32'd1);
            default: n = XCACHE_OCC_WIDTH'(32'd0);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/exec_unit_xcache_if.sv
// Bus bundle between the xcache and its neighbours: icon write channel,
// the two ALPU operand request ports and the operand return channel.
interface exec_unit_xcache_if;
    import exec_unit_xcache_pkg::*;

    type_icon_channel    icon_wr;
    type_icon_rx_channel icon_rx;
    logic                rd0_req_valid;
    type_alpu_local_addr rd0_req_idx;
    logic                rd0_req_ready;
    logic                rd1_req_valid;
    type_alpu_local_addr rd1_req_idx;
    logic                rd1_req_ready;
    type_alpu_channel_rx alpu_rx;

    modport master (
        output icon_wr, rd0_req_valid, rd0_req_idx, rd1_req_valid, rd1_req_idx,
        input  icon_rx, rd0_req_ready, rd1_req_ready, alpu_rx
    );

    modport slave (
        input  icon_wr, rd0_req_valid, rd0_req_idx, rd1_req_valid, rd1_req_idx,
        output icon_rx, rd0_req_ready, rd1_req_ready, alpu_rx
    );

endinterface

// File: rtl/exec_unit_xcache_read_port.sv
// One ALPU operand read port: request handshake against the entry array,
// one-cycle operand valid pulse and a holding operand data register.
module exec_unit_xcache_read_port
    import exec_unit_xcache_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  type_xcache_rd_req rd_req,
    input  type_xcache_data   entries [NUM_ENTRIES],
    output logic              req_ready,
    output logic              accept,
    output type_data          op_data,
    output logic              op_valid
);

    type_xcache_data sel_entry_s;
    type_data        op_data_r;
    logic            op_valid_r;

    // Select the requested slot and form the read handshake
    always_comb begin
        sel_entry_s = entries[rd_req.rd_req_idx];
        req_ready   = ~sel_entry_s.has_been_read;
        accept      = rd_req.rd_req_valid & req_ready;
    end

    // Operand register: valid pulses one cycle per accept, data holds last value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_data_r  <= {DATA_WIDTH{1'b0}};
            op_valid_r <= 1'b0;
        end else begin
            op_valid_r <= accept;
            if (accept) begin
                op_data_r <= sel_entry_s.data;
            end else begin
                op_data_r <= op_data_r;
            end
        end
    end

    assign op_data  = op_data_r;
    assign op_valid = op_valid_r;

endmodule

// File: rtl/exec_unit_xcache.sv
// Operand cache between interconnect and ALPU: one write-once/read-once slot
// per local register, two independent read-and-free ports, occupancy count.
module exec_unit_xcache
    import exec_unit_xcache_pkg::*;
#(
    parameter int EU_IDX = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    exec_unit_xcache_if.slave           xif,
    output logic [XCACHE_OCC_WIDTH-1:0] occupancy,
    output logic                        misroute_err
);

    localparam logic [LOG2_NUM_EU-1:0] OWN_EU = LOG2_NUM_EU'(EU_IDX);

    type_xcache_data             entries_r [NUM_ENTRIES];
    type_xcache_rd_req           rd0_req_s;
    type_xcache_rd_req           rd1_req_s;
    logic                        rd0_ready_s;
    logic                        rd1_ready_s;
    logic                        rd0_accept_s;
    logic                        rd1_accept_s;
    type_data                    op0_data_s;
    type_data                    op1_data_s;
    logic                        op0_valid_s;
    logic                        op1_valid_s;
    logic                        misroute_s;
    logic                        wr_ready_s;
    logic                        wr_accept_s;
    logic                        wr_drop_s;
    logic [NUM_ENTRIES-1:0]      free_s;
    logic [XCACHE_OCC_WIDTH-1:0] occ_next_s;
    logic [XCACHE_OCC_WIDTH-1:0] occupancy_r;
    logic                        misroute_err_r;

    // Bundle the raw request wires for the read ports
    always_comb begin
        rd0_req_s.rd_req_valid = xif.rd0_req_valid;
        rd0_req_s.rd_req_idx   = xif.rd0_req_idx;
        rd1_req_s.rd_req_valid = xif.rd1_req_valid;
        rd1_req_s.rd_req_idx   = xif.rd1_req_idx;
    end

    exec_unit_xcache_read_port u_rd0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_req    (rd0_req_s),
        .entries   (entries_r),
        .req_ready (rd0_ready_s),
        .accept    (rd0_accept_s),
        .op_data   (op0_data_s),
        .op_valid  (op0_valid_s)
    );

    exec_unit_xcache_read_port u_rd1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_req    (rd1_req_s),
        .entries   (entries_r),
        .req_ready (rd1_ready_s),
        .accept    (rd1_accept_s),
        .op_data   (op1_data_s),
        .op_valid  (op1_valid_s)
    );

    // Write handshake: misrouted writes are always taken and dropped
    always_comb begin
        misroute_s = xif.icon_wr.addr.is_output | (xif.icon_wr.addr.eu_idx != OWN_EU);
        if (misroute_s) begin
            wr_ready_s = 1'b1;
        end else begin
            wr_ready_s = entries_r[xif.icon_wr.addr.reg_idx].has_been_read;
        end
        wr_accept_s = xif.icon_wr.valid & wr_ready_s & ~misroute_s;
        wr_drop_s   = xif.icon_wr.valid & misroute_s;
    end

    // Per-slot free strobes and net occupancy change for this cycle
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free_s[i] = (rd0_accept_s & (xif.rd0_req_idx == LOG2_NUM_REG'(i)))
                      | (rd1_accept_s & (xif.rd1_req_idx == LOG2_NUM_REG'(i)));
        end
        occ_next_s = occupancy_r
                   + (wr_accept_s ? XCACHE_OCC_WIDTH'(32'd1) : XCACHE_OCC_WIDTH'(32'd0))
                   - distinct_frees(rd0_accept_s, rd1_accept_s,
                                    xif.rd0_req_idx == xif.rd1_req_idx);
    end

    // Entry storage; a write and a free never target the same slot in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries_r[i].data          <= {DATA_WIDTH{1'b0}};
                entries_r[i].has_been_read <= 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wr_accept_s && (xif.icon_wr.addr.reg_idx == LOG2_NUM_REG'(i))) begin
                    entries_r[i].data          <= xif.icon_wr.data;
                    entries_r[i].has_been_read <= 1'b0;
                end else if (free_s[i]) begin
                    entries_r[i].has_been_read <= 1'b1;
                end else begin
                    entries_r[i] <= entries_r[i];
                end
            end
        end
    end

    // Occupancy counter and misroute pulse register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy_r    <= {XCACHE_OCC_WIDTH{1'b0}};
            misroute_err_r <= 1'b0;
        end else begin
            occupancy_r    <= occ_next_s;
            misroute_err_r <= wr_drop_s;
        end
    end

    // Drive the bus-side outputs
    always_comb begin
        xif.icon_rx.ready        = wr_ready_s;
        xif.rd0_req_ready        = rd0_ready_s;
        xif.rd1_req_ready        = rd1_ready_s;
        xif.alpu_rx.op0_data     = op0_data_s;
        xif.alpu_rx.op0_valid    = op0_valid_s;
        xif.alpu_rx.op1_data     = op1_data_s;
        xif.alpu_rx.op1_valid    = op1_valid_s;
        xif.alpu_rx.opd_ready    = 1'b0;
    end

    assign occupancy    = occupancy_r;
    assign misroute_err = misroute_err_r;

endmodule

// File: tb/tb_exec_unit_xcache.sv
// Directed bench for exec_unit_xcache; expected operands are queued when a
// read is issued and popped when the operand valid pulse appears.
module tb_exec_unit_xcache;
    import exec_unit_xcache_pkg::*;

    logic                        clk;
    logic                        reset_n;
    logic [XCACHE_OCC_WIDTH-1:0] occupancy;
    logic                        misroute_err;
    int                          checks;
    int                          errors;
    logic [31:0]                 exp0_q [$];
    logic [31:0]                 exp1_q [$];

    exec_unit_xcache_if xif ();

    exec_unit_xcache #(.EU_IDX(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .xif          (xif),
        .occupancy    (occupancy),
        .misroute_err (misroute_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_wr(input logic is_out, input logic [1:0] eu,
                            input logic [2:0] idx, input logic [31:0] data);
        xif.icon_wr.addr.is_output = is_out;
        xif.icon_wr.addr.eu_idx    = eu;
        xif.icon_wr.addr.reg_idx   = idx;
        xif.icon_wr.data           = data;
        xif.icon_wr.valid          = 1'b1;
    endtask

    task automatic expect_op(input int port);
        logic        vld;
        logic [31:0] dat;
        logic [31:0] exp;
        int          depth;
        if (port == 0) begin
            vld   = xif.alpu_rx.op0_valid;
            dat   = xif.alpu_rx.op0_data;
            depth = exp0_q.size();
        end else begin
            vld   = xif.alpu_rx.op1_valid;
            dat   = xif.alpu_rx.op1_data;
            depth = exp1_q.size();
        end
        check($sformatf("op%0d_valid", port), 32'(vld), 32'd1);
        checks++;
        assert (depth != 0) else begin
            errors++;
            $error("FAIL op%0d_scoreboard observed=empty expected=pending", port);
        end
        if (depth != 0) begin
            exp = (port == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            check($sformatf("op%0d_data", port), dat, exp);
        end
    endtask

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        checks  = 0;
        errors  = 0;
        xif.icon_wr       = '0;
        xif.rd0_req_valid = 1'b0;
        xif.rd0_req_idx   = 3'd0;
        xif.rd1_req_valid = 1'b0;
        xif.rd1_req_idx   = 3'd0;

        // Reset state
        #12;
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_misroute", 32'(misroute_err), 32'd0);
        check("rst_alpu_rx", 32'(xif.alpu_rx != '0), 32'd0);
        check("rst_rd0_ready", 32'(xif.rd0_req_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Basic write then read of idx 3
        drive_wr(1'b0, 2'd0, 3'd3, 32'h5A);
        #1 check("wr_ready_free", 32'(xif.icon_rx.ready), 32'd1);
        tick();
        xif.icon_wr.valid = 1'b0;
        xif.rd0_req_idx   = 3'd3;
        #1 check("rd0_ready_after_wr", 32'(xif.rd0_req_ready), 32'd1);
        check("occ_after_wr", 32'(occupancy), 32'd1);
        xif.rd0_req_valid = 1'b1;
        exp0_q.push_back(32'h5A);
        tick();
        xif.rd0_req_valid = 1'b0;
        #1 expect_op(0);
        check("occ_after_rd", 32'(occupancy), 32'd0);
        check("rd0_ready_after_rd", 32'(xif.rd0_req_ready), 32'd0);
        tick();
        check("op0_valid_one_cycle", 32'(xif.alpu_rx.op0_valid), 32'd0);
        check("op0_data_hold", xif.alpu_rx.op0_data, 32'h5A);

        // Second write to a full slot stalls until the slot is read
        drive_wr(1'b0, 2'd0, 3'd3, 32'h33);
        tick();
        drive_wr(1'b0, 2'd0, 3'd3, 32'h44);
        #1 check("wr_ready_full", 32'(xif.icon_rx.ready), 32'd0);
        tick();
        check("wr_stall_ready", 32'(xif.icon_rx.ready), 32'd0);
        check("occ_stall", 32'(occupancy), 32'd1);
        xif.rd0_req_idx   = 3'd3;
        xif.rd0_req_valid = 1'b1;
        exp0_q.push_back(32'h33);
        #1 check("wr_ready_no_bypass", 32'(xif.icon_rx.ready), 32'd0);
        tick();
        xif.rd0_req_valid = 1'b0;
        #1 expect_op(0);
        check("wr_ready_after_free", 32'(xif.icon_rx.ready), 32'd1);
        check("occ_after_free", 32'(occupancy), 32'd0);
        tick();
        xif.icon_wr.valid = 1'b0;
        #1 check("occ_stalled_wr_taken", 32'(occupancy), 32'd1);
        xif.rd0_req_valid = 1'b1;
        exp0_q.push_back(32'h44);
        tick();
        xif.rd0_req_valid = 1'b0;
        #1 expect_op(0);
        check("occ_drained", 32'(occupancy), 32'd0);

        // Misrouted writes: foreign eu_idx, then is_output
        drive_wr(1'b0, 2'd1, 3'd5, 32'hDEAD);
        #1 check("misroute_eu_ready", 32'(xif.icon_rx.ready), 32'd1);
        tick();
        xif.icon_wr.valid = 1'b0;
        xif.rd1_req_idx   = 3'd5;
        #1 check("misroute_eu_pulse", 32'(misroute_err), 32'd1);
        check("misroute_eu_occ", 32'(occupancy), 32'd0);
        check("misroute_eu_not_stored", 32'(xif.rd1_req_ready), 32'd0);
        tick();
        check("misroute_eu_pulse_end", 32'(misroute_err), 32'd0);
        drive_wr(1'b1, 2'd0, 3'd6, 32'hBEEF);
        #1 check("misroute_out_ready", 32'(xif.icon_rx.ready), 32'd1);
        tick();
        xif.icon_wr.valid = 1'b0;
        xif.rd0_req_idx   = 3'd6;
        #1 check("misroute_out_pulse", 32'(misroute_err), 32'd1);
        check("misroute_out_occ", 32'(occupancy), 32'd0);
        check("misroute_out_not_stored", 32'(xif.rd0_req_ready), 32'd0);
        tick();
        check("misroute_out_pulse_end", 32'(misroute_err), 32'd0);

        // Both ports read the same slot in one cycle
        drive_wr(1'b0, 2'd0, 3'd1, 32'h11);
        tick();
        xif.icon_wr.valid = 1'b0;
        xif.rd0_req_idx   = 3'd1;
        xif.rd1_req_idx   = 3'd1;
        xif.rd0_req_valid = 1'b1;
        xif.rd1_req_valid = 1'b1;
        exp0_q.push_back(32'h11);
        exp1_q.push_back(32'h11);
        #1 check("dual_rd0_ready", 32'(xif.rd0_req_ready), 32'd1);
        check("dual_rd1_ready", 32'(xif.rd1_req_ready), 32'd1);
        check("dual_occ_before", 32'(occupancy), 32'd1);
        tick();
        xif.rd0_req_valid = 1'b0;
        xif.rd1_req_valid = 1'b0;
        #1 expect_op(0);
        expect_op(1);
        check("dual_occ_after", 32'(occupancy), 32'd0);

        // Write idx 2 and read idx 1 in the same cycle
        drive_wr(1'b0, 2'd0, 3'd1, 32'h22);
        tick();
        drive_wr(1'b0, 2'd0, 3'd2, 32'h77);
        xif.rd0_req_idx   = 3'd1;
        xif.rd0_req_valid = 1'b1;
        exp0_q.push_back(32'h22);
        #1 check("concur_wr_ready", 32'(xif.icon_rx.ready), 32'd1);
        check("concur_rd_ready", 32'(xif.rd0_req_ready), 32'd1);
        check("concur_occ_before", 32'(occupancy), 32'd1);
        tick();
        xif.icon_wr.valid = 1'b0;
        xif.rd0_req_valid = 1'b0;
        xif.rd1_req_idx   = 3'd2;
        #1 expect_op(0);
        check("concur_occ_after", 32'(occupancy), 32'd1);
        check("concur_idx2_ready", 32'(xif.rd1_req_ready), 32'd1);
        xif.rd1_req_valid = 1'b1;
        exp1_q.push_back(32'h77);
        tick();
        xif.rd1_req_valid = 1'b0;
        #1 expect_op(1);
        check("concur_occ_drained", 32'(occupancy), 32'd0);

        // Fill every slot, read two, then reset asynchronously mid-stream
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            drive_wr(1'b0, 2'd0, 3'(i), 32'h100 + 32'(i));
            tick();
        end
        xif.icon_wr.valid = 1'b0;
        #1 check("fill_occ", 32'(occupancy), 32'(NUM_ENTRIES));
        xif.rd0_req_idx   = 3'd0;
        xif.rd1_req_idx   = 3'd7;
        xif.rd0_req_valid = 1'b1;
        xif.rd1_req_valid = 1'b1;
        exp0_q.push_back(32'h100);
        exp1_q.push_back(32'h107);
        tick();
        xif.rd0_req_valid = 1'b0;
        xif.rd1_req_valid = 1'b0;
        expect_op(0);
        expect_op(1);
        check("fill_occ_after_rd", 32'(occupancy), 32'(NUM_ENTRIES - 2));
        #2 reset_n = 1'b0;
        #1 check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_op0_valid", 32'(xif.alpu_rx.op0_valid), 32'd0);
        check("arst_op1_valid", 32'(xif.alpu_rx.op1_valid), 32'd0);
        check("arst_misroute", 32'(misroute_err), 32'd0);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            xif.rd0_req_idx = 3'(i);
            xif.rd1_req_idx = 3'(i);
            #1 check($sformatf("arst_rd0_ready_%0d", i), 32'(xif.rd0_req_ready), 32'd0);
            check($sformatf("arst_rd1_ready_%0d", i), 32'(xif.rd1_req_ready), 32'd0);
        end

        check("sb0_empty", 32'(exp0_q.size()), 32'd0);
        check("sb1_empty", 32'(exp1_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
